// File: rtl/ahf_cache_pkg.sv
// Shared types and default geometry for the write-back data cache.
// Holds the controller state enum and the default parameter values.
package ahf_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    TAGUPD
  } state_e;

  localparam int DEF_AW   = 14;
  localparam int DEF_DW   = 14;
  localparam int DEF_NBLK = 8;
  localparam int DEF_WPB  = 16;

  localparam int DEF_OFFW = $clog2(DEF_WPB);
  localparam int DEF_IDXW = $clog2(DEF_NBLK);
  localparam int DEF_TAGW = DEF_AW - DEF_OFFW;

endpackage

// File: rtl/ahf_tag_cam_v.sv
// Fully associative tag/valid CAM for the data cache.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset (clears valid)
//   lk_tag_i     lookup tag
//   wr_en_i      install wr_tag_i into entry wr_idx_i and mark it valid
//   rd_idx_i     entry whose stored tag appears on rd_tag_o
//   match_o      per-entry match vector (one-hot or zero)
//   hit_idx_o    encoded index of the matching entry
//   inv_any_o    at least one entry invalid
//   inv_idx_o    lowest-index invalid entry
module ahf_tag_cam_v
  import ahf_cache_pkg::*;
#(
  parameter int NBLK = DEF_NBLK,
  parameter int TAGW = DEF_TAGW,
  localparam int IDXW = $clog2(NBLK)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [TAGW-1:0] lk_tag_i,
  input  logic            wr_en_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic [TAGW-1:0] wr_tag_i,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic [NBLK-1:0] match_o,
  output logic [IDXW-1:0] hit_idx_o,
  output logic            inv_any_o,
  output logic [IDXW-1:0] inv_idx_o,
  output logic [TAGW-1:0] rd_tag_o
);

  logic [TAGW-1:0] tag_q [NBLK];
  logic [NBLK-1:0] valid_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags need no reset: an entry is only trusted when valid.
  always_ff @(posedge Clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  always_comb begin
    match_o   = '0;
    hit_idx_o = '0;
    for (int i = 0; i < NBLK; i++) begin
      match_o[i] = valid_q[i] & (tag_q[i] == lk_tag_i);
      if (match_o[i]) begin
        hit_idx_o = IDXW'(i);
      end
    end
  end

  // Descending scan so the lowest invalid index wins.
  always_comb begin
    inv_idx_o = '0;
    for (int i = NBLK - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_idx_o = IDXW'(i);
      end
    end
  end

  assign inv_any_o = ~&valid_q;
  assign rd_tag_o  = tag_q[rd_idx_i];

endmodule

// File: rtl/ahf_dcache_wb_v.sv
// Fully associative write-back, write-allocate data cache controller.
// Optional perf counters enabled by macro AHF_DCACHE_PERF_EN.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   cpu_addr/cpu_wdata    CPU word address and store data
//   cpu_rd/cpu_wr         load/store request (both high = store)
//   cpu_rdata             load data, valid when cpu_rd=1 and stall=0
//   stall                 request not yet serviced
//   mem_addr/mem_wdata    memory word address and write-back data
//   mem_wren              memory write strobe (write-back only)
//   mem_rdata             memory read data, one cycle after mem_addr
//   hit_cnt/miss_cnt/wb_cnt  saturating 16-bit counters (macro only)
module ahf_dcache_wb_v
  import ahf_cache_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int NBLK = DEF_NBLK,
  parameter int WPB  = DEF_WPB
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata
`ifdef AHF_DCACHE_PERF_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt,
  output logic [15:0]   wb_cnt
`endif
);

  localparam int OFFW = $clog2(WPB);
  localparam int IDXW = $clog2(NBLK);
  localparam int TAGW = AW - OFFW;

  logic [OFFW-1:0] off;
  logic [TAGW-1:0] ctag;

  assign off  = cpu_addr[OFFW-1:0];
  assign ctag = cpu_addr[AW-1:OFFW];

  logic [DW-1:0]   data_q [NBLK][WPB];
  state_e          state_q;
  logic [OFFW:0]   cnt_q;
  logic [IDXW-1:0] vptr_q;
  logic [IDXW-1:0] victim_q;
  logic            vfromptr_q;
  logic [TAGW-1:0] vtag_q;
  logic [NBLK-1:0] dirty_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            mem_wren_q;

  logic [NBLK-1:0] match;
  logic [IDXW-1:0] hit_idx;
  logic            inv_any;
  logic [IDXW-1:0] inv_idx;
  logic [TAGW-1:0] rd_tag;

  logic            idle;
  logic            req;
  logic            hit;
  logic            miss;
  logic            wr_hit;
  logic [IDXW-1:0] victim_c;
  logic            vdirty_c;
  logic [OFFW:0]   cnt_inc;
  logic [OFFW-1:0] cnt_dec;

  assign idle   = (state_q == IDLE);
  assign req    = cpu_rd | cpu_wr;
  assign hit    = |match;
  assign miss   = idle & req & ~hit;
  assign wr_hit = idle & cpu_wr & hit;

  // Invalid-first victim; only when all blocks are valid do we
  // fall back to the round-robin pointer.
  assign victim_c = inv_any ? inv_idx : vptr_q;
  assign vdirty_c = ~inv_any & dirty_q[victim_c];

  assign cnt_inc = cnt_q + 1'b1;
  assign cnt_dec = cnt_q[OFFW-1:0] - 1'b1;

  ahf_tag_cam_v #(
    .NBLK (NBLK),
    .TAGW (TAGW)
  ) u_cam (
    .Clk       (Clk),
    .Reset     (Reset),
    .lk_tag_i  (ctag),
    .wr_en_i   (state_q == TAGUPD),
    .wr_idx_i  (victim_q),
    .wr_tag_i  (ctag),
    .rd_idx_i  (victim_c),
    .match_o   (match),
    .hit_idx_o (hit_idx),
    .inv_any_o (inv_any),
    .inv_idx_o (inv_idx),
    .rd_tag_o  (rd_tag)
  );

  // Memory-side outputs are registered, so each state computes
  // the address/data the next cycle must present.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vptr_q      <= '0;
      victim_q    <= '0;
      vfromptr_q  <= 1'b0;
      vtag_q      <= '0;
      dirty_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            victim_q   <= victim_c;
            vfromptr_q <= ~inv_any;
            vtag_q     <= rd_tag;
            cnt_q      <= '0;
            if (vdirty_c) begin
              state_q     <= WB;
              mem_wren_q  <= 1'b1;
              mem_addr_q  <= {rd_tag, {OFFW{1'b0}}};
              mem_wdata_q <= data_q[victim_c][0];
            end else begin
              state_q    <= FILL;
              mem_addr_q <= {ctag, {OFFW{1'b0}}};
            end
          end else if (wr_hit) begin
            dirty_q[hit_idx] <= 1'b1;
          end
        end
        WB: begin
          if (cnt_q[OFFW-1:0] == '1) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= {ctag, {OFFW{1'b0}}};
          end else begin
            cnt_q       <= cnt_inc;
            mem_addr_q  <= {vtag_q, cnt_inc[OFFW-1:0]};
            mem_wdata_q <= data_q[victim_q][cnt_inc[OFFW-1:0]];
          end
        end
        FILL: begin
          if (cnt_q[OFFW]) begin
            state_q <= TAGUPD;
          end else begin
            cnt_q <= cnt_inc;
            if (!cnt_inc[OFFW]) begin
              mem_addr_q <= {ctag, cnt_inc[OFFW-1:0]};
            end
          end
        end
        TAGUPD: begin
          dirty_q[victim_q] <= 1'b0;
          if (vfromptr_q) begin
            vptr_q <= vptr_q + 1'b1;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Data array is left uninitialised on reset; fill data lags the
  // issued address by one cycle, hence cnt-1 as the write index.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == FILL && cnt_q != '0) begin
        data_q[victim_q][cnt_dec] <= mem_rdata;
      end else if (wr_hit) begin
        data_q[hit_idx][off] <= cpu_wdata;
      end
    end
  end

  assign cpu_rdata = (idle & cpu_rd & hit) ? data_q[hit_idx][off] : '0;
  assign stall     = ~idle | (req & ~hit);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;

`ifdef AHF_DCACHE_PERF_EN
  logic hit_ev;
  logic wb_ev;

  assign hit_ev = req & ~stall;
  assign wb_ev  = miss & vdirty_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_ev && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (miss && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
      if (wb_ev && wb_cnt != 16'hFFFF) begin
        wb_cnt <= wb_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahf_dcache_wb_v.sv
// Directed testbench for ahf_dcache_wb_v at default geometry.
// Miss penalty = stall cycles after the miss-detection cycle.
module tb_ahf_dcache_wb_v;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [13:0] cpu_addr = '0;
  logic [13:0] cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [13:0] cpu_rdata;
  logic        stall;
  logic [13:0] mem_addr;
  logic [13:0] mem_wdata;
  logic        mem_wren;
  logic [13:0] mem_rdata = '0;
`ifdef AHF_DCACHE_PERF_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  ahf_dcache_wb_v dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
`ifdef AHF_DCACHE_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  logic [13:0] mem  [16384];
  logic [13:0] gold [16384];
  int          wren_tot = 0;

  always @(posedge Clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge Clk) begin
    if (mem_wren) wren_tot <= wren_tot + 1;
  end

  function automatic logic [13:0] f(input logic [13:0] a);
    return a ^ 14'h2A5A;
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [13:0] addr;
    logic [13:0] wdata;
    int          pen;
    logic [13:0] rdata;
    logic [13:0] wbb;
  } vec_t;

  vec_t tv [28];

  function automatic vec_t mk(input logic rd, input logic wr,
                              input logic [13:0] addr,
                              input logic [13:0] wdata,
                              input int pen,
                              input logic [13:0] rdata,
                              input logic [13:0] wbb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.pen = pen; v.rdata = rdata; v.wbb = wbb;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic chk_idle(input int id);
    chk("idle_stall", id, stall, 0);
    chk("idle_wren", id, mem_wren, 0);
    chk("idle_maddr", id, mem_addr, 0);
    chk("idle_mwdata", id, mem_wdata, 0);
    chk("idle_rdata", id, cpu_rdata, 0);
  endtask

  logic [13:0] s_addr [64];
  logic [13:0] s_wd   [64];
  logic        s_wren [64];

  task automatic run_vec(input int id);
    vec_t        v;
    int          n;
    int          wc;
    int          base;
    logic        ok;
    logic [13:0] fb;
    v = tv[id];
    @(posedge Clk);
    #1;
    cpu_rd = v.rd; cpu_wr = v.wr;
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    @(negedge Clk);
    n = 0;
    while (stall && n < 64) begin
      @(negedge Clk);
      if (stall) begin
        s_addr[n] = mem_addr;
        s_wd[n] = mem_wdata;
        s_wren[n] = mem_wren;
        n++;
      end
    end
    chk("stall_end", id, stall, 0);
    chk("penalty", id, n, v.pen);
    if (v.rd && !v.wr) chk("rdata", id, cpu_rdata, v.rdata);
    if (v.pen > 0) begin
      ok = 1'b1;
      wc = 0;
      base = 0;
      for (int i = 0; i < n; i++) wc += s_wren[i] ? 1 : 0;
      if (v.pen == 34) begin
        for (int i = 0; i < 16; i++) begin
          if (s_addr[i] !== 14'(v.wbb + i)) ok = 1'b0;
          if (s_wd[i] !== gold[v.wbb + i]) ok = 1'b0;
        end
        base = 16;
      end
      fb = v.addr & 14'h3FF0;
      if (n < base + 16) ok = 1'b0;
      else
        for (int i = 0; i < 16; i++)
          if (s_addr[base + i] !== 14'(fb + i)) ok = 1'b0;
      chk("sweep", id, ok, 1);
      chk("wren_cnt", id, wc, (v.pen == 34) ? 16 : 0);
    end
    if (v.wr) gold[v.addr] = v.wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = f(14'(i));
      gold[i] = f(14'(i));
    end

    tv[0] = mk(1, 0, 14'h0023, 0, 18, f(14'h0023), 0);
    tv[1] = mk(1, 0, 14'h0025, 0, 0, f(14'h0025), 0);
    tv[2] = mk(0, 1, 14'h0024, 14'h1ABC, 0, 0, 0);
    tv[3] = mk(1, 0, 14'h0024, 0, 0, 14'h1ABC, 0);
    for (int k = 1; k <= 7; k++)
      tv[3 + k] = mk(1, 0, 14'(k * 256), 0, 18, f(14'(k * 256)), 0);
    tv[11] = mk(1, 0, 14'h0800, 0, 34, f(14'h0800), 14'h0020);
    tv[12] = mk(1, 0, 14'h0900, 0, 18, f(14'h0900), 0);
    tv[13] = mk(1, 0, 14'h0200, 0, 0, f(14'h0200), 0);
    tv[14] = mk(1, 0, 14'h0800, 0, 0, f(14'h0800), 0);
    tv[15] = mk(1, 0, 14'h0100, 0, 18, f(14'h0100), 0);
    tv[16] = mk(1, 0, 14'h0023, 0, 18, f(14'h0023), 0);
    tv[17] = mk(1, 0, 14'h0024, 0, 0, 14'h1ABC, 0);
    tv[18] = mk(1, 1, 14'h0023, 14'h0055, 0, 0, 0);
    tv[19] = mk(1, 0, 14'h0023, 0, 0, 14'h0055, 0);
    for (int k = 1; k <= 7; k++)
      tv[19 + k] = mk(1, 0, 14'(k * 256), 0, 18, f(14'(k * 256)), 0);
    tv[27] = mk(1, 0, 14'h0B00, 0, 34, f(14'h0B00), 14'h0020);

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk_idle(0);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Abandon a clean fill at cycle 5 with a synchronous reset.
    @(posedge Clk);
    #1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0A03;
    @(negedge Clk);
    chk("rst_missdet", 0, stall, 1);
    repeat (6) @(negedge Clk);
    chk("rst_fill5", 0, mem_addr, 14'h0A05);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cpu_rd = 1'b0;
    @(negedge Clk);
    chk_idle(1);

    for (int i = 16; i < 28; i++) run_vec(i);

    @(posedge Clk);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(negedge Clk);
    chk("end_stall", 0, stall, 0);
    chk("mem_0023", 0, mem[14'h0023], 14'h0055);
    chk("mem_0024", 0, mem[14'h0024], 14'h1ABC);
    chk("wren_total", 0, wren_tot, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
